// File: rtl/cu_dispatch_arb_pkg.sv
// cu_dispatch_arb_pkg: shared encodings for the compute-unit dispatcher and result arbiter.
package cu_dispatch_arb_pkg;
  localparam int NUM_UNITS = 3;
  localparam logic [1:0] UNIT_ANY = 2'd3;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;
  function automatic logic [1:0] lowest_free(input logic [NUM_UNITS-1:0] busy);
    return !busy[0] ? 2'd0 : !busy[1] ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/cu_dispatch_arb_rr_arb3.sv
// rr_arb3: three-way round-robin picker, search begins one past the last grant.
module rr_arb3 (
  input  logic [2:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [2:0] grant_o,
  output logic       any_o
);
  logic [1:0] p0, p1, p2;
  always_comb begin
    p0 = last_grant_i == 2'd0 ? 2'd1 : last_grant_i == 2'd1 ? 2'd2 : 2'd0;
    p1 = last_grant_i == 2'd0 ? 2'd2 : last_grant_i == 2'd1 ? 2'd0 : 2'd1;
    p2 = last_grant_i == 2'd0 ? 2'd0 : last_grant_i == 2'd1 ? 2'd1 : 2'd2;
    grant_o = req_i[p0] ? 3'b001 << p0 :
              req_i[p1] ? 3'b001 << p1 :
              req_i[p2] ? 3'b001 << p2 : 3'b000;
    any_o = |req_i;
  end
endmodule

// File: rtl/cu_dispatch_arb.sv
// cu_dispatch_arb: issues instructions to three compute units and round-robins their results
// into a single output register.
module cu_dispatch_arb
  import cu_dispatch_arb_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [INSTR_W-1:0]    instr_i,
  output logic [2:0]            cu_valid_o,
  input  logic [2:0]            cu_ready_i,
  output logic [INSTR_W-1:0]    cu_instr_o,
  input  logic [2:0]            res_valid_i,
  input  logic [3*DATA_W-1:0]   res_data_i,
  output logic [2:0]            res_ack_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [1:0]            out_unit_o,
  output logic                  err_o
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [1:0]           tgt_q, tgt_d, lg_q, lg_d, out_unit_q, out_unit_d, sel, g;
  logic [2:0]           busy_q, busy_d, grant;
  logic [7:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 err_q, err_d, out_valid_q, out_valid_d;
  logic                 free, accept, hs, tmo, load, any;
  rr_arb3 u_rr (
    .req_i        (res_valid_i),
    .last_grant_i (lg_q),
    .grant_o      (grant),
    .any_o        (any)
  );
  assign sel           = instr_i[INSTR_W-1 -: 2];
  assign free          = sel == UNIT_ANY ? ~&busy_q : ~busy_q[sel];
  assign instr_ready_o = state_q == ST_IDLE && ena_i && free;
  assign accept        = instr_valid_i && instr_ready_o;
  assign cu_valid_o    = state_q == ST_ISSUE ? 3'b001 << tgt_q : 3'b000;
  assign hs            = |(cu_valid_o & cu_ready_i);
  assign tmo           = state_q == ST_ISSUE && !hs && cnt_q == TO_LAST;
  // Gated by rst_n so no result is acknowledged while the design is held in reset.
  assign load          = rst_n && ena_i && (!out_valid_q || out_ready_i) && any;
  assign res_ack_o     = load ? grant : 3'b000;
  assign g             = grant[1] ? 2'd1 : grant[2] ? 2'd2 : 2'd0;
  assign cu_instr_o    = instr_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_unit_o    = out_unit_q;
  assign err_o         = err_q;
  always_comb begin
    state_d     = accept ? ST_ISSUE : (hs || tmo) ? ST_IDLE : state_q;
    instr_d     = accept ? instr_i : instr_q;
    tgt_d       = accept ? (sel == UNIT_ANY ? lowest_free(busy_q) : sel) : tgt_q;
    cnt_d       = (accept || tmo) ? 8'd0 : (state_q == ST_ISSUE && !hs) ? cnt_q + 8'd1 : cnt_q;
    err_d       = tmo;
    // A new issue to the unit whose result is being acked wins over the clear.
    busy_d      = (busy_q & ~res_ack_o) | (hs ? cu_valid_o : 3'b000);
    out_valid_d = load || (out_valid_q && !out_ready_i);
    out_data_d  = load ? res_data_i[g*DATA_W +: DATA_W] : out_data_q;
    out_unit_d  = load ? g : out_unit_q;
    lg_d        = load ? g : lg_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      tgt_q       <= 2'd0;
      cnt_q       <= 8'd0;
      err_q       <= 1'b0;
      busy_q      <= 3'b000;
      lg_q        <= 2'd2;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_unit_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      lg_q        <= lg_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_unit_q  <= out_unit_d;
    end
  end
endmodule

// File: tb/tb_cu_dispatch_arb.sv
// tb_cu_dispatch_arb: directed scenarios plus a randomized run against a behavioural model.
module tb_cu_dispatch_arb;
  localparam int TIMEOUT = 255;
  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0, instr_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] instr = '0, cu_instr;
  logic [2:0]  cu_valid, cu_ready = '0, res_valid = '0, res_ack;
  logic [23:0] res_data = '0;
  logic        instr_ready, out_valid, err;
  logic [7:0]  out_data;
  logic [1:0]  out_unit;
  int vectors = 0, miscompares = 0;
  cu_dispatch_arb #(.INSTR_W(16), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_i(instr), .cu_valid_o(cu_valid), .cu_ready_i(cu_ready), .cu_instr_o(cu_instr),
    .res_valid_i(res_valid), .res_data_i(res_data), .res_ack_o(res_ack), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_data_o(out_data), .out_unit_o(out_unit), .err_o(err)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; instr_valid = 1'b0; instr = '0; cu_ready = '0;
    res_valid = '0; res_data = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; instr_valid = 1'b1; instr = 16'hFFFF; cu_ready = 3'b111;
    res_valid = 3'b111; res_data = 24'h123456; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if ({cu_valid, res_ack, out_valid, err} !== 8'h00 || out_data !== 8'h00 || out_unit !== 2'd0 || cu_instr !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got cuv=%b ack=%b ov=%b err=%b od=%h ou=%0d ci=%h, want all zero",
               cu_valid, res_ack, out_valid, err, out_data, out_unit, cu_instr);
    end
    vectors++;
    if (instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", instr_ready);
    end
  endtask
  task automatic test_issue_fixed();
    do_reset();
    instr = 16'h4012; instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL fixed_ready: got %b want 1", instr_ready); end
    @(negedge clk);
    instr_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) cu_ready = 3'b010;
      #1;
      vectors++;
      if (cu_valid !== 3'b010 || cu_instr !== 16'h4012) begin
        miscompares++;
        $display("FAIL fixed_issue c=%0d: got cuv=%b ci=%h want cuv=010 ci=4012", c, cu_valid, cu_instr);
      end
      @(negedge clk);
    end
    cu_ready = 3'b000; instr = 16'h4000;
    #1;
    vectors++;
    if (cu_valid !== 3'b000 || instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fixed_busy: got cuv=%b rdy=%b want cuv=000 rdy=0", cu_valid, instr_ready);
    end
    instr = 16'h0000;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL fixed_other_free: got %b want 1", instr_ready); end
    res_valid = 3'b010; res_data = 24'h005500; out_ready = 1'b1;
    #1;
    vectors++;
    if (res_ack !== 3'b010) begin miscompares++; $display("FAIL fixed_ack: got %b want 010", res_ack); end
    @(negedge clk);
    res_valid = 3'b000; instr = 16'h4000;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'h55 || out_unit !== 2'd1 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_result: got ov=%b od=%h ou=%0d rdy=%b want ov=1 od=55 ou=1 rdy=1",
               out_valid, out_data, out_unit, instr_ready);
    end
  endtask
  task automatic test_any_unit();
    do_reset();
    instr = 16'h0001; instr_valid = 1'b1; cu_ready = 3'b001;
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    vectors++;
    if (cu_valid !== 3'b001) begin miscompares++; $display("FAIL any_prime: got %b want 001", cu_valid); end
    @(negedge clk);
    cu_ready = 3'b111; instr = 16'hC0AA; instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL any_ready1: got %b want 1", instr_ready); end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    vectors++;
    if (cu_valid !== 3'b010) begin miscompares++; $display("FAIL any_unit1: got %b want 010", cu_valid); end
    @(negedge clk);
    instr = 16'hC0BB; instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL any_ready2: got %b want 1", instr_ready); end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    vectors++;
    if (cu_valid !== 3'b100) begin miscompares++; $display("FAIL any_unit2: got %b want 100", cu_valid); end
    @(negedge clk);
    instr = 16'hC0CC; instr_valid = 1'b1;
    #1;
    vectors++;
    if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL any_all_busy: got %b want 0", instr_ready); end
    @(negedge clk);
    res_valid = 3'b001; res_data = 24'h0000EE; out_ready = 1'b1;
    #1;
    vectors++;
    if (res_ack !== 3'b001 || instr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL any_ack_old_busy: got ack=%b rdy=%b want ack=001 rdy=0", res_ack, instr_ready);
    end
    @(negedge clk);
    res_valid = 3'b000;
    #1;
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL any_freed: got %b want 1", instr_ready); end
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    vectors++;
    if (cu_valid !== 3'b001) begin miscompares++; $display("FAIL any_unit0: got %b want 001", cu_valid); end
    @(negedge clk);
    cu_ready = 3'b000;
  endtask
  task automatic test_rr_results();
    logic [7:0] exp_d [3] = '{8'hA0, 8'hB1, 8'hC2};
    do_reset();
    res_data = {8'hC2, 8'hB1, 8'hA0}; res_valid = 3'b111; out_ready = 1'b1;
    #1;
    vectors++;
    if (res_ack !== 3'b001) begin miscompares++; $display("FAIL rr_first_ack: got %b want 001", res_ack); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) res_valid = 3'b000;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_unit !== 2'(k)) begin
        miscompares++;
        $display("FAIL rr_out k=%0d: got ov=%b od=%h ou=%0d want ov=1 od=%h ou=%0d", k, out_valid, out_data, out_unit, exp_d[k], k);
      end
      vectors++;
      if (res_ack !== (k < 2 ? 3'(1 << (k + 1)) : 3'b000)) begin
        miscompares++;
        $display("FAIL rr_ack k=%0d: got %b want %b", k, res_ack, (k < 2 ? 3'(1 << (k + 1)) : 3'b000));
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_drain: got ov=%b want 0", out_valid); end
  endtask
  task automatic test_timeout();
    int nv = 0, nerr = 0, errc = -1;
    do_reset();
    instr = 16'h8000; instr_valid = 1'b1; cu_ready = 3'b000;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      ena = !(c >= 10 && c < 20);
      #1;
      if (cu_valid === 3'b100) nv++;
      if (err === 1'b1) begin nerr++; errc = c; end
      @(negedge clk);
    end
    ena = 1'b1;
    vectors++;
    if (nv != TIMEOUT) begin miscompares++; $display("FAIL timeout_issue_cycles: got %0d want %0d", nv, TIMEOUT); end
    vectors++;
    if (nerr != 1 || errc != TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout_err: got %0d pulses at cycle %0d want 1 pulse at cycle %0d", nerr, errc, TIMEOUT);
    end
    #1;
    vectors++;
    if (cu_valid !== 3'b000 || instr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_idle: got cuv=%b rdy=%b want cuv=000 rdy=1", cu_valid, instr_ready);
    end
  endtask
  task automatic test_hold_and_reset();
    do_reset();
    res_valid = 3'b001; res_data = 24'h00003C; out_ready = 1'b0;
    @(negedge clk);
    res_valid = 3'b010; res_data = 24'h007700;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_unit !== 2'd0 || res_ack !== 3'b000) begin
        miscompares++;
        $display("FAIL hold c=%0d: got ov=%b od=%h ou=%0d ack=%b want ov=1 od=3c ou=0 ack=000",
                 c, out_valid, out_data, out_unit, res_ack);
      end
      @(negedge clk);
    end
    instr = 16'h8123; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (cu_valid !== 3'b100) begin miscompares++; $display("FAIL midreset_issue: got %b want 100", cu_valid); end
    res_valid = 3'b111; rst_n = 1'b0;
    #1;
    vectors++;
    if ({cu_valid, res_ack, out_valid, err} !== 8'h00 || out_data !== 8'h00 || out_unit !== 2'd0 || cu_instr !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got cuv=%b ack=%b ov=%b err=%b od=%h ou=%0d ci=%h, want all zero",
               cu_valid, res_ack, out_valid, err, out_data, out_unit, cu_instr);
    end
    @(negedge clk);
    rst_n = 1'b1; res_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (err !== 1'b0 || cu_valid !== 3'b000) begin
        miscompares++;
        $display("FAIL midreset_after c=%0d: got err=%b cuv=%b want err=0 cuv=000", c, err, cu_valid);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_random();
    int m_tgt = 0, m_cnt = 0, m_lg = 2, m_ou = 0, gr, sel, lf;
    bit m_iss = 0, m_ov = 0, m_err = 0, hs, tmo, acc, free, e_rdy;
    bit [2:0] m_busy = 3'b000, e_cuv, e_ack;
    logic [15:0] m_instr = '0;
    logic [7:0] m_od = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      ena = ($urandom_range(9) != 0);
      instr_valid = 1'($urandom_range(1));
      instr = 16'($urandom);
      cu_ready = 3'($urandom) & 3'($urandom);
      res_valid = 3'($urandom) & 3'($urandom);
      res_data = 24'($urandom);
      out_ready = ($urandom_range(4) != 0);
      #1;
      sel = int'(instr[15:14]);
      lf = -1;
      for (int i = 2; i >= 0; i--) if (!m_busy[i]) lf = i;
      free = (sel == 3) ? (lf >= 0) : !m_busy[sel];
      e_rdy = !m_iss && ena && free;
      e_cuv = m_iss ? 3'(1 << m_tgt) : 3'b000;
      gr = -1;
      if (ena && (!m_ov || out_ready))
        for (int k = 1; k <= 3; k++) if (gr < 0 && res_valid[(m_lg + k) % 3]) gr = (m_lg + k) % 3;
      e_ack = gr >= 0 ? 3'(1 << gr) : 3'b000;
      vectors++;
      if (instr_ready !== e_rdy || cu_valid !== e_cuv || cu_instr !== m_instr || res_ack !== e_ack ||
          out_valid !== m_ov || out_data !== m_od || out_unit !== 2'(m_ou) || err !== m_err) begin
        miscompares++;
        $display("FAIL random c=%0d: got rdy=%b cuv=%b ci=%h ack=%b ov=%b od=%h ou=%0d err=%b want rdy=%b cuv=%b ci=%h ack=%b ov=%b od=%h ou=%0d err=%b",
                 c, instr_ready, cu_valid, cu_instr, res_ack, out_valid, out_data, out_unit, err,
                 e_rdy, e_cuv, m_instr, e_ack, m_ov, m_od, m_ou, m_err);
      end
      acc = e_rdy && instr_valid;
      hs = m_iss && cu_ready[m_tgt];
      tmo = m_iss && !hs && (m_cnt == TIMEOUT - 1);
      if (gr >= 0) m_busy[gr] = 1'b0;
      if (hs) m_busy[m_tgt] = 1'b1;
      m_err = tmo;
      if (acc) begin
        m_iss = 1; m_tgt = (sel == 3) ? lf : sel; m_instr = instr; m_cnt = 0;
      end else if (hs || tmo) m_iss = 0;
      else if (m_iss) m_cnt++;
      if (gr >= 0) begin
        m_ov = 1; m_od = res_data[gr*8 +: 8]; m_ou = gr; m_lg = gr;
      end else if (m_ov && out_ready) m_ov = 0;
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_issue_fixed();
    test_any_unit();
    test_rr_results();
    test_timeout();
    test_hold_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cu_dispatch_arb.md
CU_DISPATCH_ARB -- requirements
Module: cu_dispatch_arb

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width; bits [INSTR_W-1:INSTR_W-2] are unit_sel.
REQ-002 SHALL have parameter DATA_W, default 8, result width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum ISSUE cycles before abort (8-bit counter).
REQ-004 SHALL use a single clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 ena  in  1  design enable; low blocks new instruction and result acceptance.
REQ-008 instr_valid  in  1  upstream instruction offered.
REQ-009 instr_ready  out  1  instruction accepted when instr_valid and instr_ready are both high.
REQ-010 instr  in  INSTR_W  instruction; unit_sel 0/1/2 = fixed compute unit, 3 = any free unit.
REQ-011 cu_valid  out  3  one-hot issue strobe per compute unit.
REQ-012 cu_ready  in  3  per-unit issue acceptance.
REQ-013 cu_instr  out  INSTR_W  shared issue bus; the latched instruction, unmodified.
REQ-014 res_valid  in  3  per-unit result offered.
REQ-015 res_data  in  3*DATA_W  unit i result at [i*DATA_W +: DATA_W].
REQ-016 res_ack  out  3  one-hot; result i consumed this cycle.
REQ-017 out_valid  out  1  output register holds a result.
REQ-018 out_ready  in  1  downstream consumes when out_valid and out_ready are both high.
REQ-019 out_data  out  DATA_W  held result.
REQ-020 out_unit  out  2  index of the unit that produced out_data.
REQ-021 err  out  1  one-cycle pulse on issue timeout.

Function
REQ-022 Dispatch FSM SHALL have two states, IDLE and ISSUE.
- IDLE: instr_ready = ena and target free.
- Target free means busy[sel]==0 for fixed sel; for sel 3, at least one unit has busy==0.
REQ-023 On accept, SHALL latch instr, resolve the target (sel 3 picks the lowest-index non-busy unit), clear the timeout counter, and go to ISSUE.
REQ-024 In ISSUE, cu_valid[target] SHALL be high and held until cu_ready[target]; on that handshake busy[target] is set and the FSM returns to IDLE; throughput is 1 instruction per 2 cycles.
REQ-025 Timeout counter SHALL increment on each ISSUE cycle without handshake; on reaching TIMEOUT: drop cu_valid, pulse err, leave busy unchanged, return to IDLE, discard the instruction.
REQ-026 Once in ISSUE, the FSM SHALL continue regardless of ena.
REQ-027 busy[i] SHALL clear on the cycle after res_ack[i]; a dispatch evaluation in the same cycle sees the old busy value.
REQ-028 Result arbitration SHALL be round-robin over res_valid: search starts at last_grant+1 mod 3.
- Load condition: ena and (out_valid==0 or out_ready==1).
- Results from non-busy units are still forwarded.
REQ-029 On load, SHALL assert res_ack[g] the same cycle and register out_data = res_data[g], out_unit = g, out_valid = 1 next cycle; last_grant = g.
REQ-030 SHALL sustain one result per cycle under continuous out_ready (drain and load in the same cycle).
REQ-031 out_valid SHALL deassert after a consume with no new load; out_data and out_unit SHALL be held while out_valid==1 and out_ready==0.
REQ-032 Simultaneous instruction issue and result return on the same unit SHALL be legal; set and clear of busy apply independently, with the clear taking precedence only when issue is to a different unit.

Reset
REQ-033 On rst_n low, outputs and state SHALL reset as follows:
- FSM = IDLE; busy = 0; last_grant = 2, so unit 0 has first priority.
- out_valid, cu_valid, res_ack, err = 0; out_data, out_unit, cu_instr, counter = 0.
REQ-034 Reset mid-ISSUE SHALL abandon the instruction with no err pulse.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the unit_sel encoding (UNIT_ANY = 3), and NUM_UNITS = 3.
REQ-036 Round-robin selection SHALL be one sub-module, rr_arb3 (request[2:0], last_grant -> grant one-hot, any).

Verification
REQ-037 instr=0x4012 (sel 1) and cu_ready[1] high after 3 cycles -> cu_valid=3'b010 for 4 cycles, cu_instr=0x4012, busy[1]=1.
REQ-038 sel 3 with busy=3'b001 -> issued to unit 1; a second sel 3 -> unit 2; a third -> instr_ready=0 until a result acks.
REQ-039 res_valid=3'b111, data 0xA0/0xB1/0xC2, out_ready=1 -> outputs 0xA0/0, 0xB1/1, 0xC2/2 on consecutive cycles.
REQ-040 cu_ready held low -> err pulses exactly once after 255 ISSUE cycles, FSM returns to IDLE, busy unchanged.
REQ-041 out_ready low with out_valid high -> out_data held, res_ack=0; rst_n asserted mid-ISSUE -> all outputs 0 and no err.
